// File: rtl/chu_gpo_blink.sv
// General-purpose output slot: DATA with set/clear/toggle aliases, plus a shared
// blink timer that gates selected channels with a square-wave phase.
module chu_gpo_blink #(
    parameter int N_OUT = 8,
    parameter int PRE_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    output logic [N_OUT-1:0] dout
);

    localparam logic [4:0] A_DATA   = 5'd0;
    localparam logic [4:0] A_SET    = 5'd1;
    localparam logic [4:0] A_CLR    = 5'd2;
    localparam logic [4:0] A_TGL    = 5'd3;
    localparam logic [4:0] A_BLINK  = 5'd4;
    localparam logic [4:0] A_PERIOD = 5'd5;
    localparam logic [PRE_W-1:0] CNT_ONE = PRE_W'(1);

    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_period_wr;
    logic [N_OUT-1:0] w_wd;
    logic [N_OUT-1:0] w_nxt;
    logic             w_unused_ok;

    logic [N_OUT-1:0] r_data;
    logic [N_OUT-1:0] r_blink;
    logic [PRE_W-1:0] r_period;
    logic [PRE_W-1:0] r_cnt;
    logic             r_phase;
    logic [N_OUT-1:0] r_dout;

    assign w_wr_en     = cs & write;
    assign w_rd_en     = cs & read;
    assign w_period_wr = w_wr_en & (addr == A_PERIOD);
    assign w_wd        = wr_data[N_OUT-1:0];
    assign w_unused_ok = ^wr_data;
    assign dout        = r_dout;

    // Blinking channels follow data AND phase; the others follow data directly.
    assign w_nxt = (r_data & ~r_blink) | (r_data & r_blink & {N_OUT{r_phase}});

    // Register file writes through the slot bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_blink  <= '0;
            r_period <= '1;
        end else if (w_wr_en) begin
            case (addr)
                A_DATA:   r_data   <= w_wd;
                A_SET:    r_data   <= r_data | w_wd;
                A_CLR:    r_data   <= r_data & ~w_wd;
                A_TGL:    r_data   <= r_data ^ w_wd;
                A_BLINK:  r_blink  <= w_wd;
                A_PERIOD: r_period <= wr_data[PRE_W-1:0];
                default:  r_data   <= r_data;
            endcase
        end else begin
            r_data <= r_data;
        end
    end

    // Half-period timer; a PERIOD write restarts it so the new rate begins cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_period_wr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == r_period) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_ONE;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_nxt;
        end
    end

    // Combinational read mux, returning pre-write register contents.
    always_comb begin
        rd_data = 32'd0;
        if (w_rd_en) begin
            case (addr)
                A_DATA:   rd_data[N_OUT-1:0] = r_data;
                A_SET:    rd_data[N_OUT-1:0] = r_dout;
                A_BLINK:  rd_data[N_OUT-1:0] = r_blink;
                A_PERIOD: rd_data[PRE_W-1:0] = r_period;
                default:  rd_data = 32'd0;
            endcase
        end else begin
            rd_data = 32'd0;
        end
    end

endmodule

// File: doc/chu_gpo_blink.md
CHU_GPO_BLINK -- requirements
Module: chu_gpo_blink

Interface
REQ-001 Parameter N_OUT, default 8, number of output channels (legal range 1..32).
REQ-002 Parameter PRE_W, default 24, width of blink half-period register and counter (legal range 1..32).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs  input  1  slot select.
REQ-006 read  input  1  read strobe, qualified by cs.
REQ-007 write  input  1  write strobe, qualified by cs.
REQ-008 addr  input  5  register address within slot.
REQ-009 wr_data  input  32  write data.
REQ-010 rd_data  output  32  read data.
REQ-011 dout  output  N_OUT  registered external outputs.

Function
REQ-012 The block SHALL decode wr_en = cs & write and rd_en = cs & read; registers SHALL be written only on a clock edge with wr_en high.
REQ-013 The register map SHALL be as follows, where only bits [N_OUT-1:0] of wr_data are used unless stated otherwise:
- addr 0 DATA: write replaces data_reg.
- addr 1 SET: data_reg |= wr_data.
- addr 2 CLR: data_reg &= ~wr_data.
- addr 3 TGL: data_reg ^= wr_data.
- addr 4 BLINK_EN: write replaces blink_reg.
- addr 5 PERIOD: write replaces period_reg with wr_data[PRE_W-1:0].
- addr 6..31: writes ignored.
REQ-014 Read data SHALL be combinational:
- addr 0 returns data_reg.
- addr 1 returns dout.
- addr 4 returns blink_reg.
- addr 5 returns period_reg.
- All other addresses return 0.
- Returned values SHALL be zero-extended to 32 bits.
REQ-015 rd_data SHALL be 0 whenever rd_en is low.
REQ-016 When a read and a write target the same register in the same cycle, rd_data SHALL return the pre-write value.
REQ-017 Blink timer: a PRE_W-bit counter cnt SHALL increment every cycle.
- When cnt == period_reg, cnt SHALL return to 0 and phase SHALL toggle on that edge.
- The half-period is therefore period_reg+1 cycles.
- With period_reg = 0, phase SHALL toggle every cycle.
REQ-018 A write to PERIOD SHALL clear cnt to 0 and phase to 0 on the same edge, overriding any terminal-count toggle in that cycle.
REQ-019 The next-output value SHALL be computed per channel as nxt[i] = blink_reg[i] ? (data_reg[i] & phase) : data_reg[i].
REQ-020 dout SHALL register nxt every cycle, so a write at edge k is visible on dout at edge k+1.
REQ-021 The counter SHALL wrap naturally for period_reg = 2^PRE_W-1, with no overflow beyond PRE_W bits.
REQ-022 Clearing a blink_reg bit SHALL return that channel to static data_reg[i] on the next dout update, without affecting the timer.

Reset
REQ-023 While rst is high, the block SHALL asynchronously force data_reg, blink_reg, cnt, phase and dout to 0, and period_reg to all-ones.
REQ-024 The first rising clk edge after rst deasserts SHALL resume normal operation, with no extra latency.
REQ-025 Asserting rst mid-blink SHALL drive dout to 0 immediately, without waiting for a clock edge.

Verification
REQ-026 DATA write 0xA5 at edge k: dout = 0xA5 from edge k+1; read addr 0 returns 0x000000A5.
REQ-027 With DATA = 0x0F, writing SET 0x30, then CLR 0x03, then TGL 0xFF SHALL yield data_reg = 0x3C, then 0xC3; read addr 1 SHALL equal dout.
REQ-028 PERIOD = 3, BLINK_EN = 0x01, DATA = 0x01: dout[0] SHALL be 0 for 4 cycles, then 1 for 4 cycles, repeating; dout[7:1] SHALL hold data_reg[7:1].
REQ-029 Rewriting PERIOD mid-half-period SHALL restart the phase at 0, with the next toggle exactly period_reg+1 cycles later; with PERIOD = 0, dout[0] SHALL toggle every cycle.
REQ-030 Simultaneous read and write to addr 0 (old 0x11, new 0x22) SHALL return 0x11 that cycle and 0x22 on the next read; reads to addr 7 and reads with cs = 0 SHALL return 0.
REQ-031 Asserting rst asynchronously between edges during blinking SHALL force dout = 0 immediately; after release, read addr 5 SHALL return 2^PRE_W-1.
